fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter that shares one 32-bit FIFO instance (depth FIFO_DEPTH, usable capacity FIFO_DEPTH-1) among NUM_REQ producers.
- Sits between the producers and the FIFO write port. Drives the FIFO's write and data_in from registers.
- Tracks free space with an internal credit counter, so registered writes can never overflow the FIFO.
- Supports bounded bursts so one producer can stream several words before the grant rotates.

Parameters:
- NUM_REQ, 4: number of producers, 2..8.
- FIFO_DEPTH, 16: depth of the downstream FIFO, power of two. Credits start at FIFO_DEPTH-1.
- MAX_BURST, 4: maximum consecutive accepted words per grant, 1..FIFO_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  producer i has a word on req_data[i].
- req_data  in  32*NUM_REQ  packed producer words; word i is bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  combinational one-hot accept; a word transfers when req_valid[i] & req_ready[i].
- fifo_write  out  1  registered write strobe to the FIFO write input.
- fifo_data  out  32  registered data to the FIFO data_in.
- fifo_pop  in  1  effective FIFO pop this cycle (read & !empty, generated by the consumer side).
- credits  out  $clog2(FIFO_DEPTH)+1  current free entries, for debug and status.
- owner  out  $clog2(NUM_REQ)  current or last granted producer index.
- busy  out  1  high in BURST state.

Behaviour:
- Reset values: fifo_write=0, fifo_data=0, credits=FIFO_DEPTH-1, owner=NUM_REQ-1 (so requester 0 has first priority), busy=0, burst count=0, state=IDLE.
- While reset is high, req_ready=0.
- FSM has two states, IDLE and BURST.
- IDLE:
  - If credits>0 and any req_valid is set, pick the first set index scanning from owner+1 upward with wrap-around.
  - Assert req_ready for that index in the same cycle; the word is accepted.
  - owner<=index, burst count<=1.
  - Next state is BURST if MAX_BURST>1, else IDLE.
- BURST:
  - req_ready[owner] = req_valid[owner] & (credits>0). Only the owner may be ready.
  - On accept, burst count increments.
  - Return to IDLE on any of: burst count reaches MAX_BURST after an accept; req_valid[owner]=0; credits==0.
  - The cycle that returns to IDLE makes no new grant. Re-arbitration happens the next cycle.
- Accept path:
  - On accept, at the next edge: fifo_write<=1 and fifo_data<=selected word.
  - Otherwise fifo_write<=0 and fifo_data holds its value.
  - Latency from accept to FIFO write strobe is exactly 1 cycle.
- Credits:
  - Next value = credits - accept + fifo_pop, evaluated in the same cycle.
  - Accept and pop in the same cycle leave credits unchanged.
  - Credits never exceed FIFO_DEPTH-1 and never go below 0.
  - A pop when credits==FIFO_DEPTH-1 is illegal; flag it with an assertion and saturate.
- req_ready never depends on fifo_full. The credit counter is the sole flow control, which guarantees the FIFO never sees write while full.
- Reset asserted mid-burst:
  - Next edge returns to the reset values.
  - Any accept in that cycle is discarded: fifo_write stays 0.
- Producers must hold req_valid and req_data stable until accepted. req_ready may drop without a transfer (rotation or credits==0).
- Requests with no valid set: no grant, and owner is unchanged.

Test Plan:
- Single producer: reset, then req_valid=4'b0001 with data 0x1000..0x1005 →
  - accepts 0x1000–0x1003 in 4 consecutive cycles, owner=0;
  - one IDLE gap cycle;
  - 0x1004–0x1005 accepted;
  - fifo_write pulses each 1 cycle after accept, with data in order.
- Round-robin fairness: req_valid=4'b1111 continuously, MAX_BURST=4 →
  - grant order is 0,1,2,3,0, each with 4 words;
  - owner sequence is 0,1,2,3.
- Credit exhaustion: no pops, one producer streaming →
  - exactly 15 words accepted;
  - credits reaches 0 and req_ready stays 0;
  - one fifo_pop → credits=1 → exactly one more word accepted.
- Simultaneous accept and pop with credits=5 → credits stays 5. Pop only → 6. Accept only → 4.
- Mid-burst reset: requester 2 granted, 2 words accepted, reset for 1 cycle →
  - credits=15, fifo_write=0;
  - next grant goes to the lowest valid index starting from 0.
- Early release: requester 1 drops req_valid after 2 words while requester 3 is valid → IDLE for 1 cycle, then requester 3 is granted.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers.
// Free space is tracked with a credit counter so registered writes never overflow.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [32*NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write,
  output logic [31:0]                   fifo_data,
  input  logic                          fifo_pop,
  output logic [$clog2(FIFO_DEPTH):0]   credits,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] CRED_MAX  = CW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          write_q, write_d;
  logic [31:0]   data_q, data_d;

  logic          found;
  logic [OW-1:0] pick, cand, sel;
  logic [31:0]   sel_word;
  logic          has_credit;
  logic          accept;

  assign has_credit = (credits_q != '0);

  // Rotating priority: scan from owner+1 upward, wrapping, first valid wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(owner_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A burst ends with one idle cycle that grants nothing, whatever the reason.
  always_comb begin
    req_ready = '0;
    state_d   = state_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (found && has_credit) begin
            req_ready[pick] = 1'b1;
            owner_d         = pick;
            burst_d         = BW'(1);
            state_d         = (MAX_BURST > 1) ? S_BURST : S_IDLE;
          end
        end
        default: begin
          if (burst_q == BURST_MAX || !req_valid[owner_q] || !has_credit) begin
            state_d = S_IDLE;
          end else begin
            req_ready[owner_q] = 1'b1;
            burst_d            = burst_q + BW'(1);
          end
        end
      endcase
    end
  end

  assign accept = |(req_valid & req_ready);
  assign sel    = (state_q == S_IDLE) ? pick : owner_q;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == OW'(i)) sel_word = req_data[32*i +: 32];
    end
  end

  always_comb begin
    write_d   = accept;
    data_d    = accept ? sel_word : data_q;
    credits_d = credits_q;
    if (accept && !fifo_pop) begin
      credits_d = credits_q - CW'(1);
    end else if (!accept && fifo_pop && credits_q != CRED_MAX) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OW'(NUM_REQ - 1);
      burst_q   <= '0;
      credits_q <= CRED_MAX;
      write_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      credits_q <= credits_d;
      write_q   <= write_d;
      data_q    <= data_d;
    end
  end

  // A pop with all credits free means the consumer popped an empty FIFO.
  pop_on_empty_a: assert property (@(posedge clk) disable iff (reset)
    !(fifo_pop && credits_q == CRED_MAX));

  assign fifo_write = write_q;
  assign fifo_data  = data_q;
  assign credits    = credits_q;
  assign owner      = owner_q;
  assign busy       = (state_q == S_BURST);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level reference model.
module tb_fifo_write_arbiter;
  localparam int N    = 4;
  localparam int MB   = 4;
  localparam int CMAX = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_data;
  logic         fifo_write, fifo_pop, busy;
  logic [31:0]  fifo_data;
  logic [4:0]   credits;
  logic [1:0]   owner;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(16), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .credits(credits), .owner(owner), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: current burst holder (-1 none), words taken in burst, free credits, FIFO fill.
  int m_cur, m_owner, m_words, m_cred, occ;

  logic [3:0]  o_ready, e_ready;
  logic [1:0]  o_owner, e_owner;
  logic        o_busy, e_busy, o_wr, e_wr;
  logic [4:0]  o_cred, e_cred;
  logic [31:0] o_data, e_data;

  task automatic model_reset();
    m_cur = -1; m_owner = N - 1; m_words = 0; m_cred = CMAX; occ = 0; e_data = '0;
  endtask

  // Drive one cycle, sample before and after the edge, advance the model.
  task automatic tick(input logic rst, input logic [3:0] v, input logic [127:0] d, input logic p);
    int acc;
    acc = -1;
    reset = rst; req_valid = v; req_data = d; fifo_pop = p;
    #3;
    o_ready = req_ready; o_owner = owner; o_busy = busy; o_cred = credits;
    e_ready = '0; e_owner = 2'(m_owner); e_busy = (m_cur >= 0); e_cred = 5'(m_cred);
    if (rst) begin
      model_reset();
    end else begin
      if (m_cur >= 0) begin
        if (m_words == MB || !v[2'(m_cur)] || m_cred == 0) m_cur = -1;
        else begin acc = m_cur; m_words++; end
      end else if (m_cred > 0 && v != 4'b0) begin
        for (int k = 1; k <= N; k++)
          if (acc < 0 && v[2'((m_owner + k) % N)]) acc = (m_owner + k) % N;
        m_owner = acc; m_words = 1; m_cur = (MB > 1) ? acc : -1;
      end
      for (int i = 0; i < N; i++)
        if (i == acc) begin e_ready[i] = 1'b1; e_data = d[32*i +: 32]; end
      m_cred = m_cred - ((acc >= 0) ? 1 : 0) + (p ? 1 : 0);
      if (m_cred > CMAX) m_cred = CMAX;
      occ = occ - (p ? 1 : 0);
    end
    e_wr = (acc >= 0);
    @(posedge clk); #1;
    o_wr = fifo_write; o_data = fifo_data;
    if (e_wr) occ++;
  endtask

  task automatic show(input string tag, input int c);
    $display("FAIL %s cyc %0d: got rdy=%b own=%0d busy=%b cred=%0d wr=%b dat=%h, want rdy=%b own=%0d busy=%b cred=%0d wr=%b dat=%h",
             tag, c, o_ready, o_owner, o_busy, o_cred, o_wr, o_data,
             e_ready, e_owner, e_busy, e_cred, e_wr, e_data);
  endtask

  task automatic do_reset();
    tick(1'b1, 4'b0, 128'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    tick(1'b1, 4'hF, {4{32'hDEAD_BEEF}}, 1'b0);
    tick(1'b1, 4'hF, {4{32'hDEAD_BEEF}}, 1'b0);
    n_vec++;
    if (o_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", o_ready); end
    n_vec++;
    if (o_cred !== 5'd15 || o_owner !== 2'd3 || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: got cred=%0d own=%0d busy=%b want 15/3/0", o_cred, o_owner, o_busy);
    end
    n_vec++;
    if (o_wr !== 1'b0 || o_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_out: got wr=%b dat=%h want 0/0", o_wr, o_data);
    end
  endtask

  task automatic test_single();
    logic [6:0] seen;
    int idx;
    idx = 0; seen = '0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      tick(1'b0, 4'b0001, {96'h0, 32'h1000 + 32'(idx)}, 1'b0);
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("single", c);
      end
      seen[c] = o_ready[0];
      if (o_ready[0]) idx++;
    end
    n_vec++;
    if (seen !== 7'b1101111) begin n_bad++; $display("FAIL single_pattern: got %b want 1101111", seen); end
    n_vec++;
    if (o_wr !== 1'b1 || o_data !== 32'h1005 || o_owner !== 2'd0) begin
      n_bad++; $display("FAIL single_last: got wr=%b dat=%h own=%0d want 1/00001005/0", o_wr, o_data, o_owner);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int words[4];
    int pc[4];
    logic [127:0] d;
    for (int i = 0; i < 4; i++) begin words[i] = 0; pc[i] = 0; end
    do_reset();
    for (int c = 0; c < 25; c++) begin
      d = {32'h3300 + 32'(pc[3]), 32'h3200 + 32'(pc[2]), 32'h3100 + 32'(pc[1]), 32'h3000 + 32'(pc[0])};
      tick(1'b0, 4'hF, d, occ > 0);
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("rr", c);
      end
      for (int i = 0; i < 4; i++) if (o_ready[i]) begin
        pc[i]++; words[i]++;
        if (!o_busy) grants.push_back(i);
      end
    end
    n_vec++;
    if (grants.size() != 5) begin n_bad++; $display("FAIL rr_grants: got %0d grants want 5", grants.size()); end
    else for (int g = 0; g < 5; g++) begin
      n_vec++;
      if (grants[g] != g % 4) begin n_bad++; $display("FAIL rr_order %0d: got %0d want %0d", g, grants[g], g % 4); end
    end
    n_vec++;
    if (words[0] != 8 || words[1] != 4 || words[2] != 4 || words[3] != 4) begin
      n_bad++; $display("FAIL rr_words: got %0d/%0d/%0d/%0d want 8/4/4/4", words[0], words[1], words[2], words[3]);
    end
  endtask

  task automatic test_credits();
    int n_acc;
    n_acc = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 4'b0001, {96'h0, 32'h5000 + 32'(n_acc)}, 1'b0);
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("credits", c);
      end
      if (o_ready[0]) n_acc++;
    end
    n_vec++;
    if (n_acc != 15 || o_cred !== 5'd0 || o_ready !== 4'b0) begin
      n_bad++; $display("FAIL credit_exhaust: got acc=%0d cred=%0d rdy=%b want 15/0/0000", n_acc, o_cred, o_ready);
    end
    tick(1'b0, 4'b0001, {96'h0, 32'h5000 + 32'(n_acc)}, 1'b1);
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 4'b0001, {96'h0, 32'h5100}, 1'b0);
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("credits_pop", c);
      end
      if (o_ready[0]) n_acc++;
    end
    n_vec++;
    if (n_acc != 1) begin n_bad++; $display("FAIL credit_one_more: got %0d accepts want 1", n_acc); end
  endtask

  task automatic test_accept_pop();
    logic [4:0] want [4];
    want[0] = 5'd5; want[1] = 5'd4; want[2] = 5'd5; want[3] = 5'd6;
    do_reset();
    for (int c = 0; c < 40 && m_cred > 5; c++) tick(1'b0, 4'b0001, {96'h0, 32'h6000 + 32'(c)}, 1'b0);
    for (int c = 0; c < 4 && m_cur >= 0; c++) tick(1'b0, 4'b0000, 128'h0, 1'b0);
    tick(1'b0, 4'b0001, {96'h0, 32'h6100}, 1'b1);
    n_vec++;
    if (o_cred !== 5'd5 || o_ready !== 4'b0001) begin
      n_bad++; $display("FAIL ap_start: got cred=%0d rdy=%b want 5/0001", o_cred, o_ready);
    end
    for (int s = 0; s < 4; s++) begin
      tick(1'b0, (s == 0) ? 4'b0001 : 4'b0000, {96'h0, 32'h6101}, s >= 1 && s <= 2);
      n_vec++;
      if (o_cred !== want[s]) begin n_bad++; $display("FAIL ap_step%0d: got cred=%0d want %0d", s, o_cred, want[s]); end
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("accept_pop", s);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tick(1'b0, 4'b0100, {32'h0, 32'h7000, 64'h0}, 1'b0);
    n_vec++;
    if (o_ready !== 4'b0100) begin n_bad++; $display("FAIL mr_grant: got %b want 0100", o_ready); end
    tick(1'b0, 4'b0100, {32'h0, 32'h7001, 64'h0}, 1'b0);
    n_vec++;
    if (o_ready !== 4'b0100 || o_busy !== 1'b1) begin
      n_bad++; $display("FAIL mr_second: got rdy=%b busy=%b want 0100/1", o_ready, o_busy);
    end
    tick(1'b1, 4'b0100, {32'h0, 32'h7002, 64'h0}, 1'b0);
    n_vec++;
    if (o_ready !== 4'b0 || o_wr !== 1'b0) begin
      n_bad++; $display("FAIL mr_discard: got rdy=%b wr=%b want 0000/0", o_ready, o_wr);
    end
    tick(1'b0, 4'b1110, {32'h7300, 32'h7200, 32'h7100, 32'h0}, 1'b0);
    n_vec++;
    if (o_cred !== 5'd15 || o_owner !== 2'd3 || o_ready !== 4'b0010 || o_data !== 32'h7100) begin
      n_bad++; $display("FAIL mr_after: got cred=%0d own=%0d rdy=%b dat=%h want 15/3/0010/00007100", o_cred, o_owner, o_ready, o_data);
    end
  endtask

  task automatic test_early_release();
    logic [3:0] want [4];
    logic [3:0] vs [4];
    want[0] = 4'b0010; want[1] = 4'b0010; want[2] = 4'b0000; want[3] = 4'b1000;
    vs[0] = 4'b1010; vs[1] = 4'b1010; vs[2] = 4'b1000; vs[3] = 4'b1000;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      tick(1'b0, vs[s], {32'hB000, 32'h0, 32'hA000 + 32'(s), 32'h0}, 1'b0);
      n_vec++;
      if (o_ready !== want[s]) begin n_bad++; $display("FAIL er_step%0d: got rdy=%b want %b", s, o_ready, want[s]); end
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("early_release", s);
      end
    end
    n_vec++;
    if (o_wr !== 1'b1 || o_data !== 32'hB000) begin
      n_bad++; $display("FAIL er_write: got wr=%b dat=%h want 1/0000b000", o_wr, o_data);
    end
  endtask

  task automatic test_random();
    logic [3:0]  pv;
    logic [31:0] pw [4];
    logic        rst, p;
    pv = '0;
    for (int i = 0; i < 4; i++) pw[i] = $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      p   = !rst && occ > 0 && ($urandom_range(0, 2) != 0);
      tick(rst, pv, {pw[3], pw[2], pw[1], pw[0]}, p);
      n_vec++;
      if ({o_ready, o_owner, o_busy, o_cred, o_wr, o_data} !== {e_ready, e_owner, e_busy, e_cred, e_wr, e_data}) begin
        n_bad++; show("random", c);
      end
      for (int i = 0; i < 4; i++) begin
        if (o_ready[i] && pv[i]) begin
          pv[i] = 1'($urandom_range(0, 1)); pw[i] = $urandom;
        end else if (!pv[i]) pv[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 24) == 0) pv[i] = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; fifo_pop = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_credits();
    test_accept_pop();
    test_mid_reset();
    test_early_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
